// File: rtl/uart_cmd_wrapper.sv
// 3-byte command responder over an 8-bit UART.
// Assembles {cmd, data_hi, data_lo} from RX and sends 1-byte responses on TX.
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2);

  logic          rx_m, rx_s, busy;
  logic [BW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      busy    <= 1'b0;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!busy) begin
        if (!rx_s) begin
          busy <= 1'b1;
          cnt  <= HALF;
          bitn <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt  <= FULL;
        bitn <= bitn + 1'b1;
        // bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
        if (bitn == 4'd9) begin
          busy    <= 1'b0;
          rx_data <= sh;
          rx_rdy  <= 1'b1;
        end else if (bitn != 4'd0) begin
          sh <= {rx_s, sh[7:1]};
        end
      end
    end
  end
endmodule

module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);

  logic          busy;
  logic [BW-1:0] cnt;
  logic [3:0]    bitn;
  logic [9:0]    sh;

  assign TX = sh[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !busy) begin
        sh   <= {1'b1, tx_data, 1'b0};
        busy <= 1'b1;
        cnt  <= FULL;
        bitn <= '0;
      end else if (busy) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (bitn == 4'd9) begin
          busy    <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          sh   <= {1'b1, sh[9:1]};
          bitn <= bitn + 1'b1;
          cnt  <= FULL;
        end
      end
    end
  end
endmodule

module uart_cmd_wrapper #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int BAUD_DIV       = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);
  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t        state, nxt;
  logic [7:0]    rx_data, b0, b1;
  logic          rx_rdy, clr_rx_rdy, tx_done, trmt, tx_busy;
  logic          cap0, cap1, done, tmo;
  logic [TW-1:0] tmr;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rx_rdy(clr_rx_rdy),
    .rx_data(rx_data), .rx_rdy(rx_rdy)
  );

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst_n(rst_n), .tx_data(resp), .trmt(trmt),
    .TX(TX), .tx_done(tx_done)
  );

  assign trmt = send_resp && !tx_busy;

  always_comb begin
    nxt        = state;
    clr_rx_rdy = 1'b0;
    cap0       = 1'b0;
    cap1       = 1'b0;
    done       = 1'b0;
    tmo        = (TIMEOUT_CYCLES != 0) && (tmr == TLIM);
    unique case (state)
      IDLE: if (rx_rdy) begin
        clr_rx_rdy = 1'b1;
        cap0       = 1'b1;
        nxt        = WAIT_HI;
      end
      WAIT_HI: if (rx_rdy) begin
        clr_rx_rdy = 1'b1;
        cap1       = 1'b1;
        nxt        = WAIT_LO;
      end else if (tmo) begin
        nxt = IDLE;
      end
      WAIT_LO: if (rx_rdy) begin
        clr_rx_rdy = 1'b1;
        done       = 1'b1;
        nxt        = IDLE;
      end else if (tmo) begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      b0        <= '0;
      b1        <= '0;
      cmd       <= '0;
      data      <= '0;
      cmd_rdy   <= 1'b0;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE || cap0 || cap1 || done) tmr <= '0;
      else tmr <= tmr + 1'b1;
      if (cap0) b0 <= rx_data;
      if (cap1) b1 <= rx_data;
      if (done) begin
        cmd  <= b0;
        data <= {b1, rx_data};
      end
      // completion beats a same-cycle clear
      if (done) cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || cap0) cmd_rdy <= 1'b0;
      if (trmt) begin
        tx_busy   <= 1'b1;
        resp_sent <= 1'b0;
      end else if (tx_done) begin
        tx_busy   <= 1'b0;
        resp_sent <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: serial remote driver/receiver,
// expected commands and responses queued at issue, checked by monitors.
module tb_uart_cmd_wrapper;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int tests = 0;
  int fails = 0;
  int n_exp = 0;
  int n_seen = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  resp_q[$];
  logic        rdy_prev = 1'b0;

  uart_cmd_wrapper #(.TIMEOUT_CYCLES(5000), .BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (B) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(posedge clk);
      #1;
    end
    RX = 1'b1;
    repeat (B) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
    exp_q.push_back({c, d});
    n_exp++;
    send_byte(c);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    @(posedge clk); #1;
    resp = r;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
  endtask

  task automatic wait_sent(input string nm);
    bit hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (resp_sent) hit = 1;
    end
    chk(nm, {31'd0, resp_sent}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (cmd_rdy && !rdy_prev) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", {8'd0, cmd, data}, 32'hFFFFFFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("cmd_word", {8'd0, cmd, data}, {8'd0, e});
      end
    end
    rdy_prev = cmd_rdy;
  end

  initial begin
    logic [7:0] rb;
    @(posedge rst_n);
    forever begin
      @(negedge TX);
      repeat (B / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (B) @(negedge clk);
        rb[i] = TX;
      end
      repeat (B) @(negedge clk);
      if (resp_q.size() == 0) chk("unexpected_tx", {24'd0, rb}, 32'hFFFFFFFF);
      else chk("tx_byte", {24'd0, rb}, {24'd0, resp_q.pop_front()});
    end
  end

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", {24'd0, cmd}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    chk("rst_tx", {31'd0, TX}, 32'd1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 1: basic command
    send_cmd(8'h29, 16'hBEEF);
    chk("t1_once", n_seen, 32'd1);

    // 2: outputs hold while the next command assembles
    chk("t2_rdy_before", {31'd0, cmd_rdy}, 32'd1);
    exp_q.push_back(24'h021234);
    n_exp++;
    send_byte(8'h02);
    chk("t2_rdy_low", {31'd0, cmd_rdy}, 32'd0);
    chk("t2_hold_cmd", {24'd0, cmd}, 32'h29);
    send_byte(8'h12);
    chk("t2_hold_data", {16'd0, data}, 32'hBEEF);
    send_byte(8'h34);
    repeat (5) @(posedge clk);

    // 3: timeout drops a partial command
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (6000) @(posedge clk);
    send_cmd(8'h33, 16'h4455);
    chk("t3_data", {16'd0, data}, 32'h4455);

    // 4: response while a command is mid-receive; busy send ignored
    fork
      send_cmd(8'h3A, 16'h0102);
      begin
        repeat (50) @(posedge clk);
        resp_q.push_back(8'hA5);
        pulse_resp(8'hA5);
        chk("t4_sent_low", {31'd0, resp_sent}, 32'd0);
        repeat (40) @(posedge clk);
        pulse_resp(8'h3C);
        wait_sent("t4_sent_a5");
        repeat (3) @(posedge clk);
        resp_q.push_back(8'h5A);
        pulse_resp(8'h5A);
        chk("t4_sent_clr", {31'd0, resp_sent}, 32'd0);
        wait_sent("t4_sent_5a");
      end
    join
    repeat (50) @(posedge clk);

    // 5: clear in the completion cycle loses to set
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    chk("t5_cleared", {31'd0, cmd_rdy}, 32'd0);
    exp_q.push_back(24'h4C9E01);
    n_exp++;
    send_byte(8'h4C);
    send_byte(8'h9E);
    hit = 0;
    fork
      send_byte(8'h01);
      begin
        for (int i = 0; i < 400 && !hit; i++) begin
          @(negedge clk);
          if (dut.rx_rdy) hit = 1;
        end
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        chk("t5_rx_seen", {31'd0, hit}, 32'd1);
        chk("t5_set_wins", {31'd0, cmd_rdy}, 32'd1);
      end
    join
    repeat (5) @(posedge clk);

    // 6: reset mid-command
    send_byte(8'h07);
    send_byte(8'h08);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_cmd", {24'd0, cmd}, 32'd0);
    chk("t6_data", {16'd0, data}, 32'd0);
    chk("t6_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("t6_resp_sent", {31'd0, resp_sent}, 32'd0);
    chk("t6_tx", {31'd0, TX}, 32'd1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_cmd(8'h05, 16'h0001);
    chk("t6_new_cmd", {24'd0, cmd}, 32'h05);

    repeat (20) @(posedge clk);
    chk("cmd_q_empty", exp_q.size(), 32'd0);
    chk("cmd_count", n_seen, n_exp);
    chk("resp_q_empty", resp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
